dmem_access_ctrl: RTL and testbench

Access controller placed between the pipeline MEM stage and the word-organised data memory (8192 x 32, combinational read gated by MemRead, write on posedge Clk).
- Converts CPU byte addresses and sizes into word accesses.
- Performs sign/zero extension for sub-word loads.
- Sequences byte/halfword stores as a 2-cycle read-modify-write with pipeline stall.
- Shares the memory with a loader/debug port under bounded-wait priority arbitration.

---
 rtl/dmem_access_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dmem_access_ctrl
// Purpose : MEM-stage data-memory front end. Maps byte addresses to word
//           accesses, extends sub-word loads, runs read-modify-write for
//           sub-word stores and arbitrates a loader port with bounded wait.
// Rev     : 1.0  initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int ADDR_W       = 13,
    parameter int LDR_MAX_WAIT = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [31:0]       Cpu_addr,
    input  logic [31:0]       Cpu_wdata,
    input  logic              Cpu_read,
    input  logic              Cpu_write,
    input  logic [1:0]        Cpu_size,
    input  logic              Cpu_signed,
    output logic [31:0]       Cpu_rdata,
    output logic              Cpu_stall,
    output logic              Cpu_misalign,
    input  logic              Ldr_req,
    input  logic              Ldr_we,
    input  logic [ADDR_W-1:0] Ldr_addr,
    input  logic [31:0]       Ldr_wdata,
    output logic              Ldr_ack,
    output logic [31:0]       Ldr_rdata,
    output logic [ADDR_W-1:0] Mem_address,
    output logic              Mem_read,
    output logic              Mem_write,
    output logic [31:0]       Mem_wdata,
    input  logic [31:0]       Mem_rdata
);

    localparam int                 c_CNT_W     = (LDR_MAX_WAIT > 1) ? $clog2(LDR_MAX_WAIT) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(LDR_MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RMW_WR = 2'd1,
        S_LDR    = 2'd2
    } state_t;

    state_t              r_state;
    logic [31:0]         r_merge;
    logic [c_CNT_W-1:0]  r_wait_cnt;

    logic                w_cpu_req;
    logic                w_misalign;
    logic                w_cpu_acc;
    logic                w_subword;
    logic                w_grant;
    logic                w_rmw_start;
    logic [ADDR_W-1:0]   w_word_addr;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_data;
    logic [31:0]         w_merged;
    logic                w_unused_addr;

    assign w_word_addr   = Cpu_addr[ADDR_W+1:2];
    assign w_unused_addr = ^Cpu_addr[31:ADDR_W+2];
    assign w_cpu_req     = Cpu_read | Cpu_write;
    assign w_subword     = ~Cpu_size[1];
    assign w_misalign    = w_cpu_req &
                           (((Cpu_size == 2'b01) & Cpu_addr[0]) |
                            (Cpu_size[1] & (Cpu_addr[1:0] != 2'b00)));
    assign w_cpu_acc     = w_cpu_req & ~w_misalign;
    // Loader wins when the CPU leaves the memory free, or once it has waited long enough
    assign w_grant       = Ldr_req & (~w_cpu_acc | (r_wait_cnt == c_WAIT_LAST));
    assign w_rmw_start   = w_cpu_acc & Cpu_write & w_subword & ~w_grant;

    always_comb begin
        w_byte = Mem_rdata[7:0];
        case (Cpu_addr[1:0])
            2'd0:    w_byte = Mem_rdata[7:0];
            2'd1:    w_byte = Mem_rdata[15:8];
            2'd2:    w_byte = Mem_rdata[23:16];
            default: w_byte = Mem_rdata[31:24];
        endcase
        w_half = Cpu_addr[1] ? Mem_rdata[31:16] : Mem_rdata[15:0];
        if (Cpu_size == 2'b00)
            w_load_data = {{24{Cpu_signed & w_byte[7]}}, w_byte};
        else if (Cpu_size == 2'b01)
            w_load_data = {{16{Cpu_signed & w_half[15]}}, w_half};
        else
            w_load_data = Mem_rdata;
    end

    // Old word with only the addressed lane replaced by the store data
    always_comb begin
        w_merged = Mem_rdata;
        if (Cpu_size == 2'b00) begin
            case (Cpu_addr[1:0])
                2'd0:    w_merged[7:0]   = Cpu_wdata[7:0];
                2'd1:    w_merged[15:8]  = Cpu_wdata[7:0];
                2'd2:    w_merged[23:16] = Cpu_wdata[7:0];
                default: w_merged[31:24] = Cpu_wdata[7:0];
            endcase
        end else if (Cpu_addr[1]) begin
            w_merged[31:16] = Cpu_wdata[15:0];
        end else begin
            w_merged[15:0] = Cpu_wdata[15:0];
        end
    end

    always_comb begin
        Cpu_rdata    = 32'h0;
        Cpu_stall    = 1'b0;
        Cpu_misalign = w_misalign & (r_state != S_RMW_WR);
        Ldr_ack      = 1'b0;
        Ldr_rdata    = 32'h0;
        Mem_address  = '0;
        Mem_read     = 1'b0;
        Mem_write    = 1'b0;
        Mem_wdata    = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    Cpu_stall = w_cpu_acc;
                end else if (w_cpu_acc) begin
                    Mem_address = w_word_addr;
                    if (Cpu_write) begin
                        if (w_subword) begin
                            Mem_read  = 1'b1;
                            Cpu_stall = 1'b1;
                        end else begin
                            Mem_write = 1'b1;
                            Mem_wdata = Cpu_wdata;
                        end
                    end else begin
                        Mem_read  = 1'b1;
                        Cpu_rdata = w_load_data;
                    end
                end
            end
            S_RMW_WR: begin
                Mem_address = w_word_addr;
                Mem_write   = 1'b1;
                Mem_wdata   = r_merge;
            end
            S_LDR: begin
                Cpu_stall   = w_cpu_acc;
                Mem_address = Ldr_addr;
                Mem_read    = ~Ldr_we;
                Mem_write   = Ldr_we;
                Mem_wdata   = Ldr_we ? Ldr_wdata : 32'h0;
                Ldr_ack     = 1'b1;
                Ldr_rdata   = Ldr_we ? 32'h0 : Mem_rdata;
            end
            default: begin
                Cpu_misalign = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= S_IDLE;
            r_merge    <= 32'h0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state <= S_LDR;
                    end else if (w_rmw_start) begin
                        r_merge <= w_merged;
                        r_state <= S_RMW_WR;
                    end
                    if (!Ldr_req || w_grant)
                        r_wait_cnt <= '0;
                    else if (r_wait_cnt != c_WAIT_LAST)
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                S_RMW_WR, S_LDR: begin
                    r_state <= S_IDLE;
                    if (!Ldr_req)
                        r_wait_cnt <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_access_ctrl
// Purpose : Self-checking bench for dmem_access_ctrl with a behavioural
//           8192x32 memory, vector table and loader/RMW sequences.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dmem_access_ctrl;

    localparam int ADDR_W       = 13;
    localparam int LDR_MAX_WAIT = 8;

    logic              Clk;
    logic              Rst_n;
    logic [31:0]       Cpu_addr, Cpu_wdata, Cpu_rdata;
    logic              Cpu_read, Cpu_write, Cpu_signed, Cpu_stall, Cpu_misalign;
    logic [1:0]        Cpu_size;
    logic              Ldr_req, Ldr_we, Ldr_ack;
    logic [ADDR_W-1:0] Ldr_addr, Mem_address;
    logic [31:0]       Ldr_wdata, Ldr_rdata, Mem_wdata, Mem_rdata;
    logic              Mem_read, Mem_write;

    dmem_access_ctrl #(.ADDR_W(ADDR_W), .LDR_MAX_WAIT(LDR_MAX_WAIT)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Cpu_addr(Cpu_addr), .Cpu_wdata(Cpu_wdata), .Cpu_read(Cpu_read),
        .Cpu_write(Cpu_write), .Cpu_size(Cpu_size), .Cpu_signed(Cpu_signed),
        .Cpu_rdata(Cpu_rdata), .Cpu_stall(Cpu_stall), .Cpu_misalign(Cpu_misalign),
        .Ldr_req(Ldr_req), .Ldr_we(Ldr_we), .Ldr_addr(Ldr_addr),
        .Ldr_wdata(Ldr_wdata), .Ldr_ack(Ldr_ack), .Ldr_rdata(Ldr_rdata),
        .Mem_address(Mem_address), .Mem_read(Mem_read), .Mem_write(Mem_write),
        .Mem_wdata(Mem_wdata), .Mem_rdata(Mem_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural data memory; the bench preloads words through the poke port
    logic [31:0]       mem [0:8191];
    logic              poke_en;
    logic [ADDR_W-1:0] poke_addr;
    logic [31:0]       poke_data;

    always @(posedge Clk) begin
        if (poke_en)        mem[poke_addr]   <= poke_data;
        else if (Mem_write) mem[Mem_address] <= Mem_wdata;
    end
    assign Mem_rdata = Mem_read ? mem[Mem_address] : 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn, rd, wr;
        logic [31:0] wdata, init, exp_rdata;
        logic        exp_mis, exp_stall, exp_mr, exp_mw;
        logic [31:0] exp_mem;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];
    vec_t sb [$];
    int   n_vec, n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Cpu_addr = 32'h0; Cpu_wdata = 32'h0; Cpu_read = 1'b0; Cpu_write = 1'b0;
        Cpu_size = 2'b00; Cpu_signed = 1'b0;
        Ldr_req = 1'b0; Ldr_we = 1'b0; Ldr_addr = '0; Ldr_wdata = 32'h0;
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge Clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " rdata"}, Cpu_rdata, 32'h0);
        chk({tag, " stall"}, Cpu_stall, 1'b0);
        chk({tag, " misalign"}, Cpu_misalign, 1'b0);
        chk({tag, " ack"}, Ldr_ack, 1'b0);
        chk({tag, " ldr_rdata"}, Ldr_rdata, 32'h0);
        chk({tag, " mem_addr"}, Mem_address, 0);
        chk({tag, " mem_rw"}, {Mem_read, Mem_write}, 2'b00);
        chk({tag, " mem_wdata"}, Mem_wdata, 32'h0);
    endtask

    // Two-cycle sub-word store: stall+read first, then write of the merged word
    task automatic rmw_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                             input logic [31:0] init, input logic [31:0] exp);
        logic [31:0] ta;
        logic [ADDR_W-1:0] wa;
        ta = a; wa = ta[14:2];
        poke(wa, init);
        Cpu_addr = a; Cpu_size = sz; Cpu_wdata = wd; Cpu_write = 1'b1;
        @(negedge Clk);
        chk("rmw c1 stall", Cpu_stall, 1'b1);
        chk("rmw c1 rw", {Mem_read, Mem_write}, 2'b10);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("rmw c2 stall", Cpu_stall, 1'b0);
        chk("rmw c2 rw", {Mem_read, Mem_write}, 2'b01);
        chk("rmw c2 wdata", Mem_wdata, exp);
        chk("rmw c2 addr", Mem_address, wa);
        @(posedge Clk); #1;
        idle_inputs();
        chk("rmw mem", mem[wa], exp);
        @(negedge Clk);
        chk("rmw idle rw", {Mem_read, Mem_write}, 2'b00);
    endtask

    task automatic ldr_seq(input logic we, input logic [ADDR_W-1:0] la, input logic [31:0] wd,
                           input logic cpu_busy, input int exp_cycle, input logic [31:0] exp_rd);
        int  exp_q [$];
        logic got;
        got = 1'b0;
        Ldr_req = 1'b1; Ldr_we = we; Ldr_addr = la; Ldr_wdata = wd;
        if (cpu_busy) begin
            Cpu_read = 1'b1; Cpu_size = 2'b10; Cpu_addr = 32'h14;
        end
        exp_q.push_back(exp_cycle);
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge Clk);
            chk($sformatf("ldr c%0d stall", c), Cpu_stall, cpu_busy && (c >= exp_cycle - 1));
            if (Ldr_ack) begin
                got = 1'b1;
                chk("ldr ack cycle", c, exp_q.pop_front());
                chk("ldr rdata", Ldr_rdata, exp_rd);
            end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL ldr ack timeout: got no ack, expected ack at cycle %0d", exp_cycle);
        end
        @(posedge Clk); #1;
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] ta;
        logic [ADDR_W-1:0] wa;
        vec_t v, e;
        n_vec = 0; n_err = 0; poke_en = 1'b0;
        idle_inputs();
        Rst_n = 1'b0;

        //          addr          sz     s     rd    wr    wdata         init          exp_rdata     mis   stl   mr    mw    exp_mem
        vecs[0]  = '{32'h16,       2'b00, 1'b1, 1'b1, 1'b0, 32'h0,        32'h11223344, 32'h00000022, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11223344};
        vecs[1]  = '{32'h16,       2'b01, 1'b1, 1'b1, 1'b0, 32'h0,        32'h80001234, 32'hFFFF8000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80001234};
        vecs[2]  = '{32'h16,       2'b01, 1'b0, 1'b1, 1'b0, 32'h0,        32'h80001234, 32'h00008000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80001234};
        vecs[3]  = '{32'h14,       2'b00, 1'b1, 1'b1, 1'b0, 32'h0,        32'h112233F4, 32'hFFFFFFF4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h112233F4};
        vecs[4]  = '{32'h17,       2'b00, 1'b0, 1'b1, 1'b0, 32'h0,        32'h9A223344, 32'h0000009A, 1'b0, 1'b0, 1'b1, 1'b0, 32'h9A223344};
        vecs[5]  = '{32'h14,       2'b10, 1'b1, 1'b1, 1'b0, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D};
        vecs[6]  = '{32'h18,       2'b11, 1'b0, 1'b1, 1'b0, 32'h0,        32'h01020304, 32'h01020304, 1'b0, 1'b0, 1'b1, 1'b0, 32'h01020304};
        vecs[7]  = '{32'h80000014, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        32'h13579BDF, 32'h13579BDF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h13579BDF};
        vecs[8]  = '{32'h11,       2'b01, 1'b1, 1'b1, 1'b0, 32'h0,        32'h12345678, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678};
        vecs[9]  = '{32'h13,       2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        32'h12345678, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678};
        vecs[10] = '{32'h13,       2'b10, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678};
        vecs[11] = '{32'h20,       2'b10, 1'b0, 1'b0, 1'b1, 32'h55AA55AA, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h55AA55AA};
        vecs[12] = '{32'h24,       2'b10, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h11111111, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5};
        vecs[13] = '{32'h12,       2'b01, 1'b1, 1'b1, 1'b0, 32'h0,        32'h7FFF0000, 32'h00007FFF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h7FFF0000};

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_quiet("reset");
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(negedge Clk);
        check_quiet("idle");
        @(posedge Clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            ta = v.addr; wa = ta[14:2];
            poke(wa, v.init);
            Cpu_addr = v.addr; Cpu_size = v.size; Cpu_signed = v.sgn;
            Cpu_read = v.rd; Cpu_write = v.wr; Cpu_wdata = v.wdata;
            sb.push_back(v);
            @(negedge Clk);
            e = sb.pop_front();
            chk($sformatf("v%0d rdata", i), Cpu_rdata, e.exp_rdata);
            chk($sformatf("v%0d misalign", i), Cpu_misalign, e.exp_mis);
            chk($sformatf("v%0d stall", i), Cpu_stall, e.exp_stall);
            chk($sformatf("v%0d rw", i), {Mem_read, Mem_write}, {e.exp_mr, e.exp_mw});
            chk($sformatf("v%0d addr", i), Mem_address, (e.exp_mr | e.exp_mw) ? wa : '0);
            @(posedge Clk); #1;
            idle_inputs();
            chk($sformatf("v%0d mem", i), mem[wa], e.exp_mem);
        end

        rmw_store(32'h15, 2'b00, 32'hFFFFFFAB, 32'h11223344, 32'h1122AB44);
        rmw_store(32'h14, 2'b00, 32'h00000077, 32'h11223344, 32'h11223377);
        rmw_store(32'h27, 2'b00, 32'h000000CD, 32'h11223344, 32'hCD223344);
        rmw_store(32'h26, 2'b01, 32'hFFFF1234, 32'hAAAABBBB, 32'h1234BBBB);
        rmw_store(32'h20, 2'b01, 32'h0000CAFE, 32'hAAAABBBB, 32'hAAAACAFE);

        poke(13'd5, 32'h11223344);
        ldr_seq(1'b1, 13'd7, 32'hDEADBEEF, 1'b1, LDR_MAX_WAIT + 1, 32'h0);
        chk("ldr forced mem", mem[7], 32'hDEADBEEF);
        poke(13'd3, 32'h0BADF00D);
        ldr_seq(1'b0, 13'd3, 32'h0, 1'b0, 2, 32'h0BADF00D);
        ldr_seq(1'b1, 13'd10, 32'h12345678, 1'b0, 2, 32'h0);
        chk("ldr idle mem", mem[10], 32'h12345678);

        // Reset lands while the merged word is about to be written
        poke(13'd5, 32'h11223344);
        Cpu_addr = 32'h15; Cpu_size = 2'b00; Cpu_wdata = 32'hAB; Cpu_write = 1'b1;
        @(negedge Clk);
        chk("rst-rmw c1 stall", Cpu_stall, 1'b1);
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        idle_inputs();
        @(negedge Clk);
        chk("rst-rmw mem_write", Mem_write, 1'b0);
        @(posedge Clk); #1;
        chk("rst-rmw mem", mem[5], 32'h11223344);
        Rst_n = 1'b1;
        @(negedge Clk);
        check_quiet("post-rst");
        @(posedge Clk); #1;
        Cpu_addr = 32'h14; Cpu_size = 2'b10; Cpu_read = 1'b1;
        @(negedge Clk);
        chk("post-rst load", Cpu_rdata, 32'h11223344);
        chk("post-rst stall", Cpu_stall, 1'b0);
        @(posedge Clk); #1;
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
